text_grid_renderer: RTL and testbench

//  Parametrised character-cell renderer. Walks a COLS x LINES text grid (char code + 4-bit fg/bg attribute per cell),

---
 rtl/text_grid_renderer_if.sv | 47 ++++
 rtl/text_grid_renderer.sv | 227 ++++++++++++++++++++++
 tb/tb_text_grid_renderer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/text_grid_renderer_if.sv
// Bus bundle for text_grid_renderer: text RAM and font ROM read ports,
// SRAM write port, and the scanout-side frame signals.
// The renderer takes the master modport; the surrounding system takes slave.
interface text_grid_renderer_if #(
    parameter int COLS    = 80,
    parameter int LINES   = 30,
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 20
);
    localparam int TEXT_AW = $clog2(COLS * LINES);
    localparam int FONT_AW = 8 + $clog2(GLYPH_H);

    // Scanout side
    logic                paint_done;
    logic [ADDR_W-1:0]   vga_base;
    logic                frame_done;

    // Text RAM and font ROM: data is valid one cycle after the address
    logic [TEXT_AW-1:0]  text_addr;
    logic [15:0]         text_data;
    logic [FONT_AW-1:0]  font_addr;
    logic [GLYPH_W-1:0]  font_data;

    // SRAM write handshake: sram_req acts as valid and sram_ack as ready.
    // Once sram_req rises, sram_addr/sram_wdata stay frozen until the cycle
    // sram_ack is seen high; the write is accepted on that clock edge and
    // sram_req falls on the same edge. sram_ack while sram_req=0 means nothing.
    logic                sram_req;
    logic                sram_we;
    logic [ADDR_W-1:0]   sram_addr;
    logic [DATA_W-1:0]   sram_wdata;
    logic                sram_ack;

    modport master (
        input  paint_done, text_data, font_data, sram_ack,
        output vga_base, frame_done, text_addr, font_addr,
               sram_req, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        output paint_done, text_data, font_data, sram_ack,
        input  vga_base, frame_done, text_addr, font_addr,
               sram_req, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/text_grid_renderer.sv
// Character-cell renderer: walks the COLS x LINES text grid, looks up each
// glyph row in the font ROM, expands it to PIX_W-bit fg/bg pixels and writes
// one SRAM word per glyph row into the back half of a double-buffered
// framebuffer. Optional feature macro: CURSOR_OVERLAY_EN (blinking cursor
// drawn by swapping fg/bg of the cell under the cursor).
module text_grid_renderer #(
    parameter int COLS    = 80,
    parameter int LINES   = 30,
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 16,
    parameter int PIX_W   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 20
`ifdef CURSOR_OVERLAY_EN
    ,
    parameter int BLINK_FRAMES = 30
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    text_grid_renderer_if.master       bus,
    output logic [2:0]                 dbgState
`ifdef CURSOR_OVERLAY_EN
    ,
    input  logic [$clog2(COLS)-1:0]    cursor_col,
    input  logic [$clog2(LINES)-1:0]   cursor_line,
    input  logic                       cursor_on,
    input  logic                       cursor_blink
`endif
);
    localparam int FB_WORDS = COLS * LINES * GLYPH_H;
    localparam int COL_W    = $clog2(COLS);
    localparam int LINE_W   = $clog2(LINES);
    localparam int ROW_W    = $clog2(GLYPH_H);
    localparam int TEXT_AW  = $clog2(COLS * LINES);
    localparam int FONT_AW  = 8 + ROW_W;

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_TEXT  = 3'd1;
    localparam logic [2:0] S_FONT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] FB_BASE   = ADDR_W'(FB_WORDS);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] GLYPH_H_A = ADDR_W'(GLYPH_H);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(GLYPH_H - 1);

    // One glyph row must fill exactly one SRAM word, and rows index by bit slice
    generate
        if (GLYPH_W * PIX_W != DATA_W) begin : g_bad_word
            $error("text_grid_renderer: GLYPH_W*PIX_W must equal DATA_W");
        end
        if ((GLYPH_H & (GLYPH_H - 1)) != 0) begin : g_bad_height
            $error("text_grid_renderer: GLYPH_H must be a power of 2");
        end
    endgenerate

    logic [2:0]         state;
    logic               frontSel;
    logic [COL_W-1:0]   col;
    logic [LINE_W-1:0]  line;
    logic [ROW_W-1:0]   row;
    logic [7:0]         code;
    logic [3:0]         fgAttr;
    logic [3:0]         bgAttr;
    logic [TEXT_AW-1:0] textAddr;
    logic [FONT_AW-1:0] fontAddr;
    logic               sramReq;
    logic [ADDR_W-1:0]  sramAddr;
    logic [DATA_W-1:0]  sramWdata;
    logic               frameDone;

    logic [ROW_W-1:0]   rowNext;
    logic [ADDR_W-1:0]  renderBase;
    logic [ADDR_W-1:0]  renderAddr;
    logic [DATA_W-1:0]  pixWord;
    logic [3:0]         cellFg;
    logic [3:0]         cellBg;

`ifdef CURSOR_OVERLAY_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frameCnt;
    logic            blinkPhase;
    logic            cursorHit;

    // Blink timebase: advances once per rendered frame, phase flips on wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frameCnt   <= '0;
            blinkPhase <= 1'b1;
        end else if (state == S_INIT) begin
            if (frameCnt == FC_LAST) begin
                frameCnt   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                frameCnt <= frameCnt + 1'b1;
            end
        end
    end

    // Cell under an enabled, currently visible cursor
    always_comb begin
        cursorHit = cursor_on && (cursor_col == col) && (cursor_line == line)
                    && (!cursor_blink || blinkPhase);
    end
`endif

    // Attributes of the cell being fetched, with the cursor swap applied
    always_comb begin
        cellFg = bus.text_data[11:8];
        cellBg = bus.text_data[15:12];
`ifdef CURSOR_OVERLAY_EN
        if (cursorHit) begin
            cellFg = bus.text_data[15:12];
            cellBg = bus.text_data[11:8];
        end
`endif
    end

    // Back-buffer word address of the current glyph row
    always_comb begin
        rowNext    = row + 1'b1;
        renderBase = frontSel ? '0 : FB_BASE;
        renderAddr = renderBase
                   + (((ADDR_W'(line) * GLYPH_H_A) + ADDR_W'(row)) * COLS_A)
                   + ADDR_W'(col);
    end

    // Expand the glyph row: leftmost font bit becomes pixel 0 in the low bits
    always_comb begin
        pixWord = '0;
        for (int i = 0; i < GLYPH_W; i++) begin
            pixWord[i*PIX_W +: PIX_W] = bus.font_data[GLYPH_W-1-i]
                                      ? PIX_W'(fgAttr) : PIX_W'(bgAttr);
        end
    end

    // Render sequencer: cell fetch, glyph row fetch, SRAM write, frame swap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_INIT;
            frontSel  <= 1'b0;
            col       <= '0;
            line      <= '0;
            row       <= '0;
            code      <= '0;
            fgAttr    <= '0;
            bgAttr    <= '0;
            textAddr  <= '0;
            fontAddr  <= '0;
            sramReq   <= 1'b0;
            sramAddr  <= '0;
            sramWdata <= '0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                S_INIT: begin
                    frontSel <= ~frontSel;
                    textAddr <= '0;
                    state    <= S_TEXT;
                end
                S_TEXT: begin
                    code     <= bus.text_data[7:0];
                    fgAttr   <= cellFg;
                    bgAttr   <= cellBg;
                    fontAddr <= {bus.text_data[7:0], row};
                    state    <= S_FONT;
                end
                S_FONT: begin
                    sramAddr  <= renderAddr;
                    sramWdata <= pixWord;
                    sramReq   <= 1'b1;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    if (bus.sram_ack) begin
                        sramReq <= 1'b0;
                        if (row != ROW_LAST) begin
                            row      <= rowNext;
                            fontAddr <= {code, rowNext};
                            state    <= S_FONT;
                        end else begin
                            row <= '0;
                            if (col == COL_LAST && line == LINE_LAST) begin
                                col       <= '0;
                                line      <= '0;
                                frameDone <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                if (col == COL_LAST) begin
                                    col  <= '0;
                                    line <= line + 1'b1;
                                end else begin
                                    col <= col + 1'b1;
                                end
                                textAddr <= textAddr + 1'b1;
                                state    <= S_TEXT;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.paint_done) begin
                        state <= S_INIT;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.text_addr  = textAddr;
    assign bus.font_addr  = fontAddr;
    assign bus.sram_req   = sramReq;
    assign bus.sram_we    = sramReq;
    assign bus.sram_addr  = sramAddr;
    assign bus.sram_wdata = sramWdata;
    assign bus.vga_base   = frontSel ? FB_BASE : '0;
    assign bus.frame_done = frameDone;
    assign dbgState       = state;
endmodule

// File: tb/tb_text_grid_renderer.sv
// Directed bench for text_grid_renderer on a 2x2 grid of 2-row glyphs.
// Text RAM and font ROM are small arrays read through the bus; expected
// SRAM writes are hand-computed words pushed into an expected queue.
module tb_text_grid_renderer;
    localparam int COLS    = 2;
    localparam int LINES   = 2;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 2;
    localparam int PIX_W   = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 20;

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_TEXT  = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    text_grid_renderer_if #(
        .COLS(COLS), .LINES(LINES), .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H),
        .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) bus ();

    logic [2:0] dbgState;

`ifdef CURSOR_OVERLAY_EN
    logic [0:0] cursorCol;
    logic [0:0] cursorLine;
    logic       cursorOn;
    logic       cursorBlink;
`endif

    text_grid_renderer #(
        .COLS(COLS), .LINES(LINES), .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H),
        .PIX_W(PIX_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
`ifdef CURSOR_OVERLAY_EN
        , .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbgState(dbgState)
`ifdef CURSOR_OVERLAY_EN
        , .cursor_col(cursorCol),
        .cursor_line(cursorLine),
        .cursor_on(cursorOn),
        .cursor_blink(cursorBlink)
`endif
    );

    // Text RAM and font ROM models
    logic [15:0] textMem [0:3];
    logic [7:0]  fontMem [0:511];
    assign bus.text_data = textMem[bus.text_addr];
    assign bus.font_data = fontMem[bus.font_addr];

    // Scoreboard
    int checks = 0;
    int errors = 0;
    logic [51:0] exp_q[$];

    task automatic check(input string tag, input logic [51:0] obs, input logic [51:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-computed words for the 2x2 grid, in render order
    task automatic loadFrame(input logic [19:0] base, input logic swap1);
        logic [31:0] c1r0;
        logic [31:0] c1r1;
        c1r0 = swap1 ? 32'hC333_333C : 32'h3CCC_CCC3;
        c1r1 = swap1 ? 32'h33CC_CC33 : 32'hCC33_33CC;
        exp_q.push_back({base + 20'd0, 32'h5555_AAAA});
        exp_q.push_back({base + 20'd2, 32'hAAAA_5555});
        exp_q.push_back({base + 20'd1, c1r0});
        exp_q.push_back({base + 20'd3, c1r1});
        exp_q.push_back({base + 20'd4, 32'h0000_7777});
        exp_q.push_back({base + 20'd6, 32'h7777_0000});
        exp_q.push_back({base + 20'd5, 32'h1F1F_1F1F});
        exp_q.push_back({base + 20'd7, 32'hFFFF_FFFF});
    endtask

    // Wait for one write, check it, hold it for 'hold' cycles, then ack it.
    // hold=0 means sram_ack is already tied high.
    task automatic expectWrite(input int hold);
        logic [51:0] e;
        int n;
        e = exp_q.pop_front();
        n = 0;
        while (bus.sram_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("write_seen", 52'(bus.sram_req), 52'd1);
        check("write_we", 52'(bus.sram_we), 52'd1);
        check("write_addr", 52'(bus.sram_addr), 52'(e[51:32]));
        check("write_data", 52'(bus.sram_wdata), 52'(e[31:0]));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_req", 52'(bus.sram_req), 52'd1);
            check("hold_addr", 52'(bus.sram_addr), 52'(e[51:32]));
            check("hold_data", 52'(bus.sram_wdata), 52'(e[31:0]));
        end
        if (hold > 0) bus.sram_ack = 1'b1;
        @(negedge clk);
        if (hold > 0) bus.sram_ack = 1'b0;
        check("req_drop", 52'(bus.sram_req), 52'd0);
    endtask

    task automatic endOfFrame(input logic [19:0] vga);
        check("frame_done_pulse", 52'(bus.frame_done), 52'd1);
        check("state_done", 52'(dbgState), 52'(S_DONE));
        check("vga_base_frame", 52'(bus.vga_base), 52'(vga));
        @(negedge clk);
        check("frame_done_clear", 52'(bus.frame_done), 52'd0);
    endtask

    task automatic startFrame();
        bus.paint_done = 1'b1;
        @(negedge clk);
        bus.paint_done = 1'b0;
        check("state_init", 52'(dbgState), 52'(S_INIT));
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int holds [8];
        int n;
        holds = '{5, 5, 1, 2, 3, 1, 4, 2};

        for (int i = 0; i < 512; i++) fontMem[i] = 8'h00;
        fontMem[2] = 8'hF0; fontMem[3] = 8'h0F;
        fontMem[4] = 8'h81; fontMem[5] = 8'h3C;
        fontMem[6] = 8'hAA; fontMem[7] = 8'hFF;
        textMem[0] = 16'h5A01;
        textMem[1] = 16'hC302;
        textMem[2] = 16'h0701;
        textMem[3] = 16'h1F03;
        bus.sram_ack   = 1'b1;
        bus.paint_done = 1'b0;
`ifdef CURSOR_OVERLAY_EN
        cursorCol   = 1'b1;
        cursorLine  = 1'b0;
        cursorOn    = 1'b0;
        cursorBlink = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", 52'(bus.sram_req), 52'd0);
        check("rst_we", 52'(bus.sram_we), 52'd0);
        check("rst_addr", 52'(bus.sram_addr), 52'd0);
        check("rst_wdata", 52'(bus.sram_wdata), 52'd0);
        check("rst_text_addr", 52'(bus.text_addr), 52'd0);
        check("rst_font_addr", 52'(bus.font_addr), 52'd0);
        check("rst_vga_base", 52'(bus.vga_base), 52'd0);
        check("rst_frame_done", 52'(bus.frame_done), 52'd0);
        check("rst_state", 52'(dbgState), 52'(S_INIT));

        // Frame 1: ack tied high, render into base 0
        rst = 1'b1;
        @(negedge clk);
        check("swap_state", 52'(dbgState), 52'(S_TEXT));
        check("swap_vga_base", 52'(bus.vga_base), 52'd8);
        loadFrame(20'd0, 1'b0);
        for (int i = 0; i < 8; i++) expectWrite(0);
        endOfFrame(20'd8);
        repeat (2) @(negedge clk);
        check("wait_done", 52'(dbgState), 52'(S_DONE));

        // Frame 2: delayed ack, paint_done during render ignored
        bus.sram_ack = 1'b0;
        startFrame();
        check("vga_before_swap", 52'(bus.vga_base), 52'd8);
        @(negedge clk);
        check("vga_after_swap", 52'(bus.vga_base), 52'd0);
        loadFrame(20'd8, 1'b0);
        expectWrite(holds[0]);
        bus.paint_done = 1'b1;
        @(negedge clk);
        bus.paint_done = 1'b0;
        check("paint_ignored", 52'(dbgState == S_INIT), 52'd0);
        for (int i = 1; i < 8; i++) expectWrite(holds[i]);
        endOfFrame(20'd0);

        // Ack in S_DONE with no request pending is ignored
        bus.sram_ack = 1'b1;
        @(negedge clk);
        bus.sram_ack = 1'b0;
        check("stray_ack_req", 52'(bus.sram_req), 52'd0);
        check("stray_ack_state", 52'(dbgState), 52'(S_DONE));

        // Async reset while a write is pending
        startFrame();
        n = 0;
        while (bus.sram_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pending_req", 52'(bus.sram_req), 52'd1);
        #2 rst = 1'b0;
        #1;
        check("async_req", 52'(bus.sram_req), 52'd0);
        check("async_vga", 52'(bus.vga_base), 52'd0);
        check("async_state", 52'(dbgState), 52'(S_INIT));
        @(negedge clk);
        rst = 1'b1;
        bus.sram_ack = 1'b1;
        loadFrame(20'd0, 1'b0);
        for (int i = 0; i < 8; i++) expectWrite(0);
        endOfFrame(20'd8);

`ifdef CURSOR_OVERLAY_EN
        // Cursor on cell (1,0): steady, then blinking with BLINK_FRAMES=2
        cursorOn = 1'b1;
        startFrame();
        loadFrame(20'd8, 1'b1);
        for (int i = 0; i < 8; i++) expectWrite(0);
        endOfFrame(20'd0);
        cursorBlink = 1'b1;
        startFrame();
        loadFrame(20'd0, 1'b0);
        for (int i = 0; i < 8; i++) expectWrite(0);
        endOfFrame(20'd8);
        startFrame();
        loadFrame(20'd8, 1'b1);
        for (int i = 0; i < 8; i++) expectWrite(0);
        endOfFrame(20'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
